pattern_checker: RTL and testbench

PATTERN_CHECKER -- requirements
Module: pattern_checker

---
 rtl/pattern_checker_pkg.sv | 23 ++
 rtl/pattern_step_timer.sv | 41 ++++
 rtl/pattern_checker.sv | 141 ++++++++++++++
 tb/tb_pattern_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pattern_checker_pkg
// Purpose  : Shared state encoding and counter constants for pattern_checker.
// Revision : 1.0 - initial release
// ============================================================================
package pattern_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int              c_cnt_w   = 8;
    localparam logic [c_cnt_w-1:0] c_no_fail = 8'hFF;
    localparam logic [c_cnt_w-1:0] c_err_max = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/pattern_step_timer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_step_timer
// Purpose  : Per-slot cycle timer flagging the sample edge and the slot end.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_step_timer #(
    parameter int STEP_CYC   = 20,
    parameter int SETTLE_CYC = 10,
    parameter int CNT_W      = $clog2(STEP_CYC + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             settle_hit,
    output logic             step_hit
);

    // Hits are decoded one count early so the consuming edge is the flagged one.
    localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] c_step_last   = CNT_W'(STEP_CYC - 2);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count      = r_count;
    assign settle_hit = (r_count == c_settle_last);
    assign step_hit   = (r_count == c_step_last);

endmodule

`default_nettype wire

// File: rtl/pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : pattern_checker
// Purpose  : Applies a run of patterns to a device and checks its identity
//            and inverting outputs once per slot at a fixed settle point.
// Revision : 1.0 - initial release
// ============================================================================
import pattern_checker_pkg::*;

module pattern_checker #(
    parameter int IN_WIDTH   = 10,
    parameter int PATTERNS   = 8,
    parameter int STEP_CYC   = 20,
    parameter int SETTLE_CYC = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                pat_valid,
    input  logic [IN_WIDTH-1:0] pat_data,
    output logic                pat_ready,
    output logic [IN_WIDTH-1:0] pat_out,
    input  logic [IN_WIDTH-1:0] same_bus,
    input  logic [IN_WIDTH-1:0] inv_bus,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [7:0]          first_fail
);

    localparam int                 c_tmr_w     = $clog2(STEP_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_last_index = c_cnt_w'(PATTERNS - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [IN_WIDTH-1:0] r_pat_out;
    logic [c_cnt_w-1:0]  r_err_count;
    logic [c_cnt_w-1:0]  r_first_fail;
    logic [c_cnt_w-1:0]  r_index;
    logic                r_done;

    logic                w_start_ok;
    logic                w_capture;
    logic                w_sample;
    logic                w_advance;
    logic                w_last;
    logic                w_mismatch;
    logic                w_settle_hit;
    logic                w_step_hit;
    logic [c_tmr_w-1:0]  w_unused_count;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_capture  = (r_state == ST_LOAD) && pat_valid;
    assign w_sample   = (r_state == ST_SETTLE) && w_settle_hit;
    // When SETTLE_CYC == STEP_CYC-1 the sample edge is also the slot end.
    assign w_advance  = w_step_hit && ((r_state == ST_HOLD) || w_sample);
    assign w_last     = (r_index == c_last_index);
    assign w_mismatch = (same_bus != r_pat_out) || (inv_bus != ~r_pat_out);

    pattern_step_timer #(
        .STEP_CYC   (STEP_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .clear      (w_capture || w_start_ok),
        .enable     ((r_state == ST_SETTLE) || (r_state == ST_HOLD)),
        .count      (w_unused_count),
        .settle_hit (w_settle_hit),
        .step_hit   (w_step_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (pat_valid) w_next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (w_settle_hit) begin
                    if (w_step_hit) w_next_state = w_last ? ST_DONE : ST_LOAD;
                    else            w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_step_hit) w_next_state = w_last ? ST_DONE : ST_LOAD;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat_out    <= '0;
            r_err_count  <= '0;
            r_first_fail <= c_no_fail;
            r_index      <= '0;
            r_done       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_err_count  <= '0;
                r_first_fail <= c_no_fail;
                r_index      <= '0;
                r_done       <= 1'b0;
            end
            if (w_capture) begin
                r_pat_out <= pat_data;
            end
            if (w_sample && w_mismatch) begin
                if (r_err_count != c_err_max)  r_err_count  <= r_err_count + 8'd1;
                if (r_first_fail == c_no_fail) r_first_fail <= r_index;
            end
            if (w_advance) begin
                if (w_last) r_done  <= 1'b1;
                else        r_index <= r_index + 8'd1;
            end
        end
    end

    assign pat_ready  = (r_state == ST_LOAD);
    assign pat_out    = r_pat_out;
    assign done       = r_done;
    assign pass       = r_done && (r_err_count == '0);
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_checker
// Purpose  : Directed scoreboard bench for pattern_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_checker;

    localparam int W      = 10;
    localparam int STEP   = 20;
    localparam int SETTLE = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         pat_valid;
    logic [W-1:0] pat_data;
    logic         pat_ready;
    logic [W-1:0] pat_out;
    logic [W-1:0] same_bus;
    logic [W-1:0] inv_bus;
    logic         done;
    logic         pass;
    logic [7:0]   err_count;
    logic [7:0]   first_fail;
    logic [W-1:0] same_fault;
    logic [W-1:0] inv_fault;

    // Second instance: single pattern, sample edge coincides with slot end.
    logic         start2;
    logic         pat_valid2;
    logic [W-1:0] pat_data2;
    logic         pat_ready2;
    logic [W-1:0] pat_out2;
    logic [W-1:0] same_bus2;
    logic [W-1:0] inv_bus2;
    logic         done2;
    logic         pass2;
    logic [7:0]   err_count2;
    logic [7:0]   first_fail2;

    always #5 clk = ~clk;

    assign same_bus  = pat_out ^ same_fault;
    assign inv_bus   = ~pat_out ^ inv_fault;
    assign same_bus2 = pat_out2;
    assign inv_bus2  = ~pat_out2;

    pattern_checker dut (
        .clk(clk), .rst(rst), .start(start), .pat_valid(pat_valid), .pat_data(pat_data),
        .pat_ready(pat_ready), .pat_out(pat_out), .same_bus(same_bus), .inv_bus(inv_bus),
        .done(done), .pass(pass), .err_count(err_count), .first_fail(first_fail)
    );

    pattern_checker #(.IN_WIDTH(W), .PATTERNS(1), .STEP_CYC(4), .SETTLE_CYC(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .pat_valid(pat_valid2), .pat_data(pat_data2),
        .pat_ready(pat_ready2), .pat_out(pat_out2), .same_bus(same_bus2), .inv_bus(inv_bus2),
        .done(done2), .pass(pass2), .err_count(err_count2), .first_fail(first_fail2)
    );

    typedef struct packed {
        logic [7:0] err;
        logic [7:0] ff;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_mis = 0;
    logic [7:0] e_err;
    logic [7:0] e_ff;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_pat_out"}, pat_out, 0);
        chk({tag, "_ready"}, pat_ready, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err"}, err_count, 0);
        chk({tag, "_ff"}, first_fail, 8'hFF);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        e_err = 8'd0;
        e_ff  = 8'hFF;
        chk("start_ready", pat_ready, 1);
        chk("start_done", done, 0);
        chk("start_err", err_count, 0);
        chk("start_ff", first_fail, 8'hFF);
    endtask

    // One slot; entered after the negedge where pat_ready is expected high.
    task automatic slot(input int idx, input int dly, input logic [W-1:0] sf,
                        input logic [W-1:0] inf, input bit glitch, input bit poke, input bit last);
        exp_t         e;
        logic [W-1:0] prev;
        prev = pat_out;
        if (dly > 0) begin
            tick(dly);
            chk("wait_ready", pat_ready, 1);
            chk("wait_hold", pat_out, prev);
        end
        pat_valid = 1'b1;
        pat_data  = idx[W-1:0];
        tick(1);
        pat_valid = 1'b0;
        chk("capture", pat_out, idx);
        chk("busy_ready", pat_ready, 0);
        if ((sf | inf) != '0) begin
            if (e_err != 8'hFF) e_err = e_err + 8'd1;
            if (e_ff == 8'hFF)  e_ff  = idx[7:0];
        end
        e.err = e_err;
        e.ff  = e_ff;
        sb.push_back(e);
        for (int k = 1; k <= STEP - 1; k++) begin
            same_fault = (glitch && k == 5) ? 10'h200 : ((k == SETTLE) ? sf : '0);
            inv_fault  = (k == SETTLE) ? inf : '0;
            start      = poke && (k == 12);
            tick(1);
            if (k == SETTLE) begin
                e = sb.pop_front();
                chk("err_count", err_count, e.err);
                chk("first_fail", first_fail, e.ff);
            end
            if (k == STEP - 2) chk("hold_ready", pat_ready, 0);
        end
        same_fault = '0;
        inv_fault  = '0;
        start      = 1'b0;
        if (last) begin
            chk("done", done, 1);
            chk("pass", pass, (e_err == 8'd0));
            chk("last_out", pat_out, idx);
        end else begin
            chk("next_ready", pat_ready, 1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        pat_valid  = 1'b0;
        pat_data   = '0;
        same_fault = '0;
        inv_fault  = '0;
        start2     = 1'b0;
        pat_valid2 = 1'b0;
        pat_data2  = '0;
        e_err      = 8'd0;
        e_ff       = 8'hFF;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_reset_values("reset");

        // Ideal run.
        do_start();
        for (int i = 0; i < 8; i++) slot(i, 0, '0, '0, 1'b0, 1'b0, i == 7);
        chk("runA_err", err_count, 0);
        chk("runA_ff", first_fail, 8'hFF);

        // Same-bus fault on 3, stall before 4, glitch away from sample on 6.
        do_start();
        for (int i = 0; i < 8; i++)
            slot(i, (i == 4) ? 7 : 0, (i == 3) ? 10'h001 : '0, '0, i == 6, 1'b0, i == 7);
        chk("runB_err", err_count, 1);
        chk("runB_ff", first_fail, 3);

        // Inverting-bus faults on 2 and 5, start pulsed mid-slot and ignored.
        do_start();
        for (int i = 0; i < 8; i++)
            slot(i, 0, '0, (i == 2 || i == 5) ? 10'h080 : '0, 1'b0, 1'b1, i == 7);
        chk("runC_err", err_count, 2);
        chk("runC_ff", first_fail, 2);

        // Reset during SETTLE of pattern 6 overrides start and pat_valid.
        do_start();
        for (int i = 0; i < 6; i++) slot(i, 0, (i == 1) ? 10'h010 : '0, '0, 1'b0, 1'b0, 1'b0);
        pat_valid = 1'b1;
        pat_data  = 10'd6;
        tick(1);
        pat_valid = 1'b0;
        tick(3);
        rst       = 1'b1;
        start     = 1'b1;
        pat_valid = 1'b1;
        tick(1);
        rst       = 1'b0;
        start     = 1'b0;
        pat_valid = 1'b0;
        chk_reset_values("midrun_rst");
        tick(25);
        chk("no_resume_ready", pat_ready, 0);
        chk("no_resume_done", done, 0);

        do_start();
        for (int i = 0; i < 8; i++) slot(i, 0, '0, '0, 1'b0, 1'b0, i == 7);
        chk("runE_ff", first_fail, 8'hFF);

        // Single-pattern instance: capture, then DONE exactly three edges later.
        start2     = 1'b1;
        tick(1);
        start2     = 1'b0;
        pat_valid2 = 1'b1;
        pat_data2  = 10'h2A5;
        chk("p1_ready", pat_ready2, 1);
        tick(3);
        chk("p1_not_done", done2, 0);
        tick(1);
        pat_valid2 = 1'b0;
        chk("p1_done", done2, 1);
        chk("p1_pass", pass2, 1);
        chk("p1_out", pat_out2, 10'h2A5);
        chk("p1_ff", first_fail2, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
